sc_comp: RTL and testbench
==========================

Name: sc_comp

Overview:
- Single-cycle RV32I computer top: CPU core (instance U_SCPU), instruction ROM (U_IM) and byte-addressed data RAM (U_DM), all on one clock.
- Each rising clk edge retires exactly one instruction.
- A debug port reads any architectural register combinationally for board display and bench checks.

Parameters:
- IM_WORDS, 128, instruction ROM depth in 32-bit words.
- DM_BYTES, 512, data RAM depth in bytes.
- RESET_PC, 32'h00000000, PC value while and after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- reg_sel  in  5  register index for debug read.
- reg_data  out  32  combinational value of x[reg_sel]; x0 reads 0.

Behaviour:
- Hierarchy names are fixed for bench access:
  - top-level 32-bit signal PC (current fetch address);
  - U_SCPU.inst_in (fetched instruction) and U_SCPU.PC_out (equals PC);
  - U_SCPU.U_RF.rf[1..31], the register array;
  - U_IM.ROM[0..IM_WORDS-1], 32-bit words loaded by $readmemh;
  - U_DM.dmem[0..DM_BYTES-1], 8-bit little-endian byte array.
- Reset:
  - rstn low immediately forces PC=RESET_PC and clears rf[1..31] to 0, independent of clk.
  - dmem and ROM are not reset.
  - The first instruction executes on the first rising edge after rstn rises.
- Fetch: inst_in = ROM[PC[31:2] mod IM_WORDS], combinational; PC[1:0] ignored.
- Instruction set: full RV32I minus fence/ecall/ebreak/csr:
  - LUI, AUIPC, JAL, JALR;
  - BEQ/BNE/BLT/BGE/BLTU/BGEU;
  - LB/LH/LW/LBU/LHU, SB/SH/SW;
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI;
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Immediates: I/S/B/U/J formats, sign-extended per the RV32I spec.
- Shift amount is the low 5 bits of the operand.
- Next PC:
  - PC+4 by default;
  - PC+immB on a taken branch;
  - PC+immJ for JAL;
  - (rs1+immI) with bit0 cleared for JALR.
  - JAL/JALR write PC+4 to rd.
- Register file:
  - 2 combinational read ports plus the debug read port;
  - 1 write port, written on the rising edge;
  - writes to x0 are discarded;
  - a read of the register being written in the same cycle returns the old value.
- Data memory:
  - combinational read; write on the rising edge;
  - address taken modulo DM_BYTES;
  - little-endian;
  - halfword/word accesses use the aligned bytes at addr, addr+1(, +2, +3) with no alignment trap;
  - LB/LH sign-extend, LBU/LHU zero-extend.
- Unrecognised opcode: no register or memory write, PC advances by 4.
- Arithmetic: 32-bit, wrap-around, no overflow flags. SLT is signed, SLTU unsigned.
- PC beyond ROM depth wraps by the modulo rule and never yields X.
- Halt convention: software signals completion by jumping to 32'hF0000100. The core executes normally there; the bench detects this PC and stops.

Test Plan:
- Reset mid-run:
  - stimulus: pulse rstn low 20 ns at any time with PC at 0x00000010;
  - required: PC reads 0x00000000 before the next clk edge and all reg_data reads 0.
- Arithmetic:
  - stimulus: ADDI x5,x0,-1; ADDI x6,x0,3; ADD x7,x5,x6; reg_sel=7;
  - required: reg_data=0x00000002 after 3 edges.
  - stimulus: SLTU x8,x6,x5;
  - required: x8=1.
- Memory:
  - stimulus: x5=0x80; SW x5,0(x0); LB x9,0(x0); LBU x10,0(x0); SB x6,1(x0); LW x11,0(x0);
  - required: x9=0xFFFFFF80, x10=0x00000080, dmem[1]=0x03, x11=0x00000380.
- Control flow:
  - stimulus: BEQ x0,x0,+8;
  - required: PC advances by 8.
  - stimulus: BNE x0,x0,+8;
  - required: PC advances by 4.
  - stimulus: JAL x1,+12 at PC 0x20;
  - required: x1=0x24, PC=0x2C.
  - stimulus: JALR x0,0(x1) with x1=0x25;
  - required: PC=0x24.
- Upper immediates and x0:
  - stimulus: LUI x3,0xF0000; AUIPC x4,1 at PC 0x30; ADDI x0,x0,5;
  - required: x3=0xF0000000, x4=0x00001030, reg_sel=0 reads 0.
- Halt:
  - stimulus: LUI x3,0xF0000; ADDI x3,x3,0x100; JALR x0,0(x3);
  - required: PC=0xF0000100, never X.

Source files
------------

// File: rtl/sc_comp.sv
// Single-cycle RV32I computer: core, instruction ROM and byte-wide data RAM on one clock.
// One instruction retires per rising clk edge; reg_sel/reg_data expose the register file.

module sc_rf (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  dbg_sel,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1_c,
  output logic [31:0] rd2_c,
  output logic [31:0] dbg_data_c
);
  logic [31:0] rf [1:31];

  // x0 has no storage; reads of the register being written see the old value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i < 32; i++) rf[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

  assign rd1_c      = (ra1 == 5'd0)     ? 32'd0 : rf[ra1];
  assign rd2_c      = (ra2 == 5'd0)     ? 32'd0 : rf[ra2];
  assign dbg_data_c = (dbg_sel == 5'd0) ? 32'd0 : rf[dbg_sel];
endmodule

module sc_im #(
  parameter int unsigned IM_WORDS = 128
) (
  input  logic [29:0] word_addr,
  output logic [31:0] inst_c
);
  localparam int unsigned IM_AW = (IM_WORDS > 1) ? $clog2(IM_WORDS) : 1;

  logic [31:0] ROM [IM_WORDS];

  // Out-of-range fetches wrap so the core never sees an undefined word
  assign inst_c = ROM[IM_AW'(word_addr % 30'(IM_WORDS))];
endmodule

module sc_dm #(
  parameter int unsigned DM_BYTES = 512
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [1:0]  size,
  output logic [31:0] rdata_c
);
  localparam int unsigned DM_AW = (DM_BYTES > 1) ? $clog2(DM_BYTES) : 1;

  logic [7:0]       dmem [DM_BYTES];
  logic [DM_AW-1:0] a0, a1, a2, a3;

  function automatic logic [DM_AW-1:0] wrap(input logic [31:0] a);
    return DM_AW'(a % 32'(DM_BYTES));
  endfunction

  // Each successive byte lane wraps independently around the RAM end
  assign a0 = wrap(addr);
  assign a1 = wrap(32'(a0) + 32'd1);
  assign a2 = wrap(32'(a1) + 32'd1);
  assign a3 = wrap(32'(a2) + 32'd1);

  assign rdata_c = {dmem[a3], dmem[a2], dmem[a1], dmem[a0]};

  always_ff @(posedge clk) begin
    if (we) begin
      dmem[a0] <= wdata[7:0];
      if (size != 2'd0) dmem[a1] <= wdata[15:8];
      if (size == 2'd2) begin
        dmem[a2] <= wdata[23:16];
        dmem[a3] <= wdata[31:24];
      end
    end
  end
endmodule

module sc_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst_in,
  output logic [31:0] PC_out,
  output logic [31:0] mem_addr_c,
  output logic [31:0] mem_wdata_c,
  output logic        mem_we_c,
  output logic [1:0]  mem_size_c,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data_c
);
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  logic [31:0] pc_q, pc_next, pc_plus4;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, rd_wd, load_v;
  logic        rd_we, take;

  assign opcode = inst_in[6:0];
  assign rd     = inst_in[11:7];
  assign f3     = inst_in[14:12];
  assign rs1    = inst_in[19:15];
  assign rs2    = inst_in[24:20];

  assign imm_i = {{20{inst_in[31]}}, inst_in[31:20]};
  assign imm_s = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
  assign imm_b = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
  assign imm_u = {inst_in[31:12], 12'd0};
  assign imm_j = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};

  assign pc_plus4    = pc_q + 32'd4;
  assign PC_out      = pc_q;
  assign mem_wdata_c = rs2_v;

  sc_rf U_RF (
    .clk        (clk),
    .rstn       (rstn),
    .ra1        (rs1),
    .ra2        (rs2),
    .dbg_sel    (reg_sel),
    .we         (rd_we),
    .wa         (rd),
    .wd         (rd_wd),
    .rd1_c      (rs1_v),
    .rd2_c      (rs2_v),
    .dbg_data_c (reg_data_c)
  );

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[4:0];
    case (op)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << sh;
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> sh) : (a >> sh);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= RESET_PC;
    else       pc_q <= pc_next;
  end

  // Load extension from the raw little-endian word at the access address
  always_comb begin
    load_v = mem_rdata;
    case (f3)
      3'b000:  load_v = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  load_v = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  load_v = {24'd0, mem_rdata[7:0]};
      3'b101:  load_v = {16'd0, mem_rdata[15:0]};
      default: load_v = mem_rdata;
    endcase
  end

  // Decode/execute; unknown opcodes fall through to PC+4 with no side effects
  always_comb begin
    pc_next    = pc_plus4;
    rd_we      = 1'b0;
    rd_wd      = 32'd0;
    mem_addr_c = rs1_v + imm_i;
    mem_we_c   = 1'b0;
    mem_size_c = f3[1:0];
    take       = 1'b0;
    case (opcode)
      OPC_LUI: begin
        rd_we = 1'b1;
        rd_wd = imm_u;
      end
      OPC_AUIPC: begin
        rd_we = 1'b1;
        rd_wd = pc_q + imm_u;
      end
      OPC_JAL: begin
        rd_we   = 1'b1;
        rd_wd   = pc_plus4;
        pc_next = pc_q + imm_j;
      end
      OPC_JALR: begin
        rd_we   = 1'b1;
        rd_wd   = pc_plus4;
        pc_next = (rs1_v + imm_i) & ~32'd1;
      end
      OPC_BR: begin
        case (f3)
          3'b000:  take = (rs1_v == rs2_v);
          3'b001:  take = (rs1_v != rs2_v);
          3'b100:  take = ($signed(rs1_v) <  $signed(rs2_v));
          3'b101:  take = ($signed(rs1_v) >= $signed(rs2_v));
          3'b110:  take = (rs1_v <  rs2_v);
          3'b111:  take = (rs1_v >= rs2_v);
          default: take = 1'b0;
        endcase
        if (take) pc_next = pc_q + imm_b;
      end
      OPC_LOAD: begin
        rd_we = (f3 != 3'b011) && (f3[2:1] != 2'b11);
        rd_wd = load_v;
      end
      OPC_STORE: begin
        mem_addr_c = rs1_v + imm_s;
        mem_we_c   = rstn && (f3 inside {3'b000, 3'b001, 3'b010});
      end
      OPC_IMM: begin
        rd_we = 1'b1;
        rd_wd = alu(f3, (f3 == 3'b101) && inst_in[30], rs1_v, imm_i);
      end
      OPC_OP: begin
        rd_we = 1'b1;
        rd_wd = alu(f3, inst_in[30], rs1_v, rs2_v);
      end
      default: ;
    endcase
  end
endmodule

module sc_comp #(
  parameter int unsigned IM_WORDS = 128,
  parameter int unsigned DM_BYTES = 512,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);
  logic [31:0] PC;
  logic [31:0] inst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  mem_size;

  sc_cpu #(.RESET_PC(RESET_PC)) U_SCPU (
    .clk         (clk),
    .rstn        (rstn),
    .inst_in     (inst),
    .PC_out      (PC),
    .mem_addr_c  (mem_addr),
    .mem_wdata_c (mem_wdata),
    .mem_we_c    (mem_we),
    .mem_size_c  (mem_size),
    .mem_rdata   (mem_rdata),
    .reg_sel     (reg_sel),
    .reg_data_c  (reg_data)
  );

  sc_im #(.IM_WORDS(IM_WORDS)) U_IM (
    .word_addr (PC[31:2]),
    .inst_c    (inst)
  );

  sc_dm #(.DM_BYTES(DM_BYTES)) U_DM (
    .clk     (clk),
    .addr    (mem_addr),
    .wdata   (mem_wdata),
    .we      (mem_we),
    .size    (mem_size),
    .rdata_c (mem_rdata)
  );
endmodule

// File: tb/tb_sc_comp.sv
// Bench for sc_comp: loads a program into the ROM, steps it one edge at a time and
// compares PC and the debug register port against expectations queued per step.

module tb_sc_comp;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] O_IMM = 7'h13, O_OP = 7'h33, O_LD = 7'h03, O_ST = 7'h23;
  localparam logic [6:0] O_BR = 7'h63, O_JALR = 7'h67, O_JAL = 7'h6F, O_LUI = 7'h37, O_AUIPC = 7'h17;
  localparam logic [31:0] HALT_PC = 32'hF000_0100;

  sc_comp dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] npc;
    logic [4:0]  sel;
    logic [31:0] val;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [4:0]  sel;
    logic [31:0] val;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [11:0] im;
    im = 12'(imm);
    return {im, 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] r_t(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), O_OP};
  endfunction

  function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], O_ST};
  endfunction

  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], O_BR};
  endfunction

  function automatic logic [31:0] u_t(int imm20, int rd, logic [6:0] op);
    return {20'(imm20), 5'(rd), op};
  endfunction

  function automatic logic [31:0] j_t(int imm, int rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), O_JAL};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_vec(input logic [31:0] addr, input logic [31:0] inst, input logic [31:0] npc,
                          input int sel, input logic [31:0] val, input string name);
    vec_t v;
    v.addr = addr; v.inst = inst; v.npc = npc; v.sel = 5'(sel); v.val = val; v.name = name;
    vt.push_back(v);
  endtask

  // Drive one retirement: queue the expectation, clock once, then compare
  task automatic step(input vec_t v);
    exp_t e;
    check({v.name, " fetch"}, dut.PC, v.addr);
    e.name = v.name; e.pc = v.npc; e.sel = v.sel; e.val = v.val;
    reg_sel = v.sel;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    reg_sel = e.sel;
    #1;
    check({e.name, " pc"}, dut.PC, e.pc);
    check({e.name, " rd"}, reg_data, e.val);
  endtask

  initial begin
    // addr, instruction, next PC, reg to observe, its value after the edge
    push_vec(32'h00, i_t(-1, 0, 0, 5, O_IMM),   32'h04, 5,  32'hFFFF_FFFF, "addi_m1");
    push_vec(32'h04, i_t(3, 0, 0, 6, O_IMM),    32'h08, 6,  32'h0000_0003, "addi_3");
    push_vec(32'h08, r_t(0, 6, 5, 0, 7),        32'h0C, 7,  32'h0000_0002, "add");
    push_vec(32'h0C, r_t(0, 5, 6, 3, 8),        32'h10, 8,  32'h0000_0001, "sltu");
    push_vec(32'h10, b_t(8, 0, 0, 0),           32'h18, 0,  32'h0000_0000, "beq_taken");
    push_vec(32'h18, b_t(8, 0, 0, 1),           32'h1C, 24, 32'h0000_0000, "bne_not");
    push_vec(32'h1C, i_t(32'h80, 0, 0, 5, O_IMM), 32'h20, 5, 32'h0000_0080, "addi_80");
    push_vec(32'h20, j_t(12, 1),                32'h2C, 1,  32'h0000_0024, "jal");
    push_vec(32'h2C, i_t(1, 1, 0, 1, O_IMM),    32'h30, 1,  32'h0000_0025, "addi_x1");
    push_vec(32'h30, u_t(1, 4, O_AUIPC),        32'h34, 4,  32'h0000_1030, "auipc");
    push_vec(32'h34, u_t(32'hF0000, 3, O_LUI),  32'h38, 3,  32'hF000_0000, "lui");
    push_vec(32'h38, i_t(5, 0, 0, 0, O_IMM),    32'h3C, 0,  32'h0000_0000, "x0_write");
    push_vec(32'h3C, i_t(0, 1, 0, 0, O_JALR),   32'h24, 1,  32'h0000_0025, "jalr_odd");
    push_vec(32'h24, s_t(0, 5, 0, 2),           32'h28, 5,  32'h0000_0080, "sw");
    push_vec(32'h28, j_t(32'h18, 0),            32'h40, 0,  32'h0000_0000, "jal_x0");
    push_vec(32'h40, i_t(0, 0, 0, 9, O_LD),     32'h44, 9,  32'hFFFF_FF80, "lb");
    push_vec(32'h44, i_t(0, 0, 4, 10, O_LD),    32'h48, 10, 32'h0000_0080, "lbu");
    push_vec(32'h48, s_t(1, 6, 0, 0),           32'h4C, 6,  32'h0000_0003, "sb");
    push_vec(32'h4C, i_t(0, 0, 2, 11, O_LD),    32'h50, 11, 32'h0000_0380, "lw");
    push_vec(32'h50, r_t(32'h20, 5, 6, 0, 12),  32'h54, 12, 32'hFFFF_FF83, "sub");
    push_vec(32'h54, u_t(32'h80000, 14, O_LUI), 32'h58, 14, 32'h8000_0000, "lui_msb");
    push_vec(32'h58, i_t(32'h404, 14, 5, 13, O_IMM), 32'h5C, 13, 32'hF800_0000, "srai");
    push_vec(32'h5C, i_t(4, 14, 5, 15, O_IMM),  32'h60, 15, 32'h0800_0000, "srli");
    push_vec(32'h60, r_t(0, 6, 14, 2, 16),      32'h64, 16, 32'h0000_0001, "slt");
    push_vec(32'h64, r_t(0, 6, 14, 3, 17),      32'h68, 17, 32'h0000_0000, "sltu_big");
    push_vec(32'h68, i_t(-1, 6, 4, 18, O_IMM),  32'h6C, 18, 32'hFFFF_FFFC, "xori");
    push_vec(32'h6C, i_t(32'h10, 6, 6, 19, O_IMM), 32'h70, 19, 32'h0000_0013, "ori");
    push_vec(32'h70, i_t(32'h300, 11, 7, 20, O_IMM), 32'h74, 20, 32'h0000_0300, "andi");
    push_vec(32'h74, r_t(0, 6, 6, 1, 21),       32'h78, 21, 32'h0000_0018, "sll");
    push_vec(32'h78, s_t(6, 18, 0, 1),          32'h7C, 18, 32'hFFFF_FFFC, "sh");
    push_vec(32'h7C, i_t(6, 0, 1, 22, O_LD),    32'h80, 22, 32'hFFFF_FFFC, "lh");
    push_vec(32'h80, i_t(6, 0, 5, 23, O_LD),    32'h84, 23, 32'h0000_FFFC, "lhu");
    push_vec(32'h84, b_t(8, 6, 14, 4),          32'h8C, 0,  32'h0000_0000, "blt");
    push_vec(32'h8C, b_t(8, 6, 14, 6),          32'h90, 0,  32'h0000_0000, "bltu_not");
    push_vec(32'h90, b_t(8, 6, 14, 7),          32'h98, 0,  32'h0000_0000, "bgeu");
    push_vec(32'h98, b_t(8, 14, 6, 5),          32'hA0, 0,  32'h0000_0000, "bge");
    push_vec(32'hA0, 32'h0000_0000,             32'hA4, 24, 32'h0000_0000, "bad_opcode");
    push_vec(32'hA4, r_t(32'h20, 6, 14, 5, 25), 32'hA8, 25, 32'hF000_0000, "sra");
    push_vec(32'hA8, r_t(0, 6, 14, 5, 26),      32'hAC, 26, 32'h1000_0000, "srl");
    push_vec(32'hAC, i_t(32'h100, 3, 0, 3, O_IMM), 32'hB0, 3, HALT_PC, "addi_halt");
    push_vec(32'hB0, i_t(0, 3, 0, 5, O_JALR),   HALT_PC, 5, 32'h0000_00B4, "jalr_halt");

    for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = i_t(0, 0, 0, 0, O_IMM);
    foreach (vt[i]) dut.U_IM.ROM[vt[i].addr[8:2]] = vt[i].inst;
    // Words that must never execute: each would set x24
    dut.U_IM.ROM[32'h14 >> 2] = i_t(1, 0, 0, 24, O_IMM);
    dut.U_IM.ROM[32'h88 >> 2] = i_t(1, 0, 0, 24, O_IMM);
    dut.U_IM.ROM[32'h94 >> 2] = i_t(1, 0, 0, 24, O_IMM);
    dut.U_IM.ROM[32'h9C >> 2] = i_t(1, 0, 0, 24, O_IMM);

    #12;
    check("reset pc", dut.PC, 32'h0);
    reg_sel = 5'd5;
    #1;
    check("reset x5", reg_data, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vt[i]) step(vt[i]);

    check("halt pc known", {31'd0, $isunknown(dut.PC)}, 32'h0);
    check("dmem0", {24'd0, dut.U_DM.dmem[0]}, 32'h0000_0080);
    check("dmem1", {24'd0, dut.U_DM.dmem[1]}, 32'h0000_0003);
    check("dmem7", {24'd0, dut.U_DM.dmem[7]}, 32'h0000_00FF);

    // Long reset after halt: every register reads zero through the debug port
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("halt reset pc", dut.PC, 32'h0);
    for (int s = 0; s < 32; s++) begin
      reg_sel = 5'(s);
      #1;
      check($sformatf("clr x%0d", s), reg_data, 32'h0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // Run to PC 0x10, then a 20 ns asynchronous reset pulse between edges
    for (int i = 0; i < 4; i++) step(vt[i]);
    #2;
    rstn = 1'b0;
    #1;
    check("midrun pc", dut.PC, 32'h0);
    for (int s = 0; s < 10; s++) begin
      reg_sel = 5'(s);
      #1;
      check($sformatf("midrun x%0d", s), reg_data, 32'h0);
    end
    #9;
    rstn = 1'b1;
    step(vt[0]);
    step(vt[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule
